// File: rtl/lstm_delta_ctrl.sv
// Sequencer for the LSTM backprop delta datapath: fetch, load and a fixed micro-program per hidden unit.
// Outputs are computed from the next state and registered, so each strobe lines up with its state.
module lstm_delta_ctrl #(
   parameter int N_UNITS   = 8,
   parameter int ADDR_W    = 3,
   parameter int MICRO_LEN = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_start,
   input  logic              i_no_next,
   input  logic              i_rd_valid,
   output logic              o_rd_en,
   output logic [ADDR_W-1:0] o_addr,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_dstate_valid,
   output logic              o_dgate_valid,
   output logic [1:0]        o_gate_id,
   output logic [1:0]        o_sel_in1,
   output logic [1:0]        o_sel_in2,
   output logic [1:0]        o_sel_in4,
   output logic              o_sel_in3,
   output logic [2:0]        o_sel_in5,
   output logic [1:0]        o_sel_x1_1,
   output logic [1:0]        o_sel_x2_2,
   output logic [1:0]        o_sel_as_2,
   output logic [1:0]        o_sel_temp,
   output logic              o_sel_x1_2,
   output logic              o_sel_as_1,
   output logic              o_sel_addsub
);
   localparam int USTEP_W = $clog2(MICRO_LEN);
   localparam logic [USTEP_W-1:0] LAST_STEP = USTEP_W'(MICRO_LEN - 1);
   localparam logic [ADDR_W-1:0]  LAST_UNIT = ADDR_W'(N_UNITS - 1);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, LOAD, COMPUTE, DONE} state_t;

   state_t              state, next_state;
   logic [ADDR_W-1:0]   unit, next_unit;
   logic [USTEP_W-1:0]  ustep, next_ustep;
   logic                no_next, next_no_next;

   logic              rd_en_nx, busy_nx, done_nx, dstate_valid_nx, dgate_valid_nx;
   logic [ADDR_W-1:0] addr_nx;
   logic [1:0]        gate_id_nx, sel_in1_nx, sel_in2_nx, sel_in4_nx;
   logic              sel_in3_nx, sel_x1_2_nx, sel_as_1_nx, sel_addsub_nx;
   logic [2:0]        sel_in5_nx;
   logic [1:0]        sel_x1_1_nx, sel_x2_2_nx, sel_as_2_nx, sel_temp_nx;

   // State, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         unit           <= '0;
         ustep          <= '0;
         no_next        <= 1'b0;
         o_rd_en        <= 1'b0;
         o_addr         <= '0;
         o_busy         <= 1'b0;
         o_done         <= 1'b0;
         o_dstate_valid <= 1'b0;
         o_dgate_valid  <= 1'b0;
         o_gate_id      <= 2'b00;
         o_sel_in1      <= 2'b00;
         o_sel_in2      <= 2'b00;
         o_sel_in3      <= 1'b0;
         o_sel_in4      <= 2'b00;
         o_sel_in5      <= 3'b111;
         o_sel_x1_1     <= 2'b00;
         o_sel_x2_2     <= 2'b00;
         o_sel_as_2     <= 2'b00;
         o_sel_temp     <= 2'b10;
         o_sel_x1_2     <= 1'b0;
         o_sel_as_1     <= 1'b0;
         o_sel_addsub   <= 1'b0;
      end else begin
         state          <= next_state;
         unit           <= next_unit;
         ustep          <= next_ustep;
         no_next        <= next_no_next;
         o_rd_en        <= rd_en_nx;
         o_addr         <= addr_nx;
         o_busy         <= busy_nx;
         o_done         <= done_nx;
         o_dstate_valid <= dstate_valid_nx;
         o_dgate_valid  <= dgate_valid_nx;
         o_gate_id      <= gate_id_nx;
         o_sel_in1      <= sel_in1_nx;
         o_sel_in2      <= sel_in2_nx;
         o_sel_in3      <= sel_in3_nx;
         o_sel_in4      <= sel_in4_nx;
         o_sel_in5      <= sel_in5_nx;
         o_sel_x1_1     <= sel_x1_1_nx;
         o_sel_x2_2     <= sel_x2_2_nx;
         o_sel_as_2     <= sel_as_2_nx;
         o_sel_temp     <= sel_temp_nx;
         o_sel_x1_2     <= sel_x1_2_nx;
         o_sel_as_1     <= sel_as_1_nx;
         o_sel_addsub   <= sel_addsub_nx;
      end
   end

   // Next-state and counter logic.
   always_comb begin
      next_state   = state;
      next_unit    = unit;
      next_ustep   = ustep;
      next_no_next = no_next;
      case (state)
         IDLE: begin
            if (i_start) begin
               next_state   = FETCH;
               next_unit    = '0;
               next_no_next = i_no_next;
            end else begin
               next_state = IDLE;
            end
         end
         FETCH: next_state = WAIT;
         WAIT: begin
            if (i_rd_valid) next_state = LOAD;
            else            next_state = WAIT;
         end
         LOAD: begin
            next_state = COMPUTE;
            next_ustep = '0;
         end
         COMPUTE: begin
            if (ustep == LAST_STEP) begin
               next_ustep = '0;
               if (unit == LAST_UNIT) begin
                  next_state = DONE;
               end else begin
                  next_state = FETCH;
                  next_unit  = unit + ADDR_W'(1);
               end
            end else begin
               next_ustep = ustep + USTEP_W'(1);
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Output decode from the upcoming state; idle select set unless overridden.
   always_comb begin
      rd_en_nx        = 1'b0;
      addr_nx         = '0;
      busy_nx         = 1'b0;
      done_nx         = 1'b0;
      dstate_valid_nx = 1'b0;
      dgate_valid_nx  = 1'b0;
      gate_id_nx      = 2'b00;
      sel_in1_nx      = 2'b00;
      sel_in2_nx      = 2'b00;
      sel_in3_nx      = 1'b0;
      sel_in4_nx      = 2'b00;
      sel_in5_nx      = 3'b111;
      sel_x1_1_nx     = 2'b00;
      sel_x2_2_nx     = 2'b00;
      sel_as_2_nx     = 2'b00;
      sel_temp_nx     = 2'b10;
      sel_x1_2_nx     = 1'b0;
      sel_as_1_nx     = 1'b0;
      sel_addsub_nx   = 1'b0;
      case (next_state)
         FETCH: begin
            rd_en_nx = 1'b1;
            addr_nx  = next_unit;
            busy_nx  = 1'b1;
         end
         WAIT: begin
            addr_nx = next_unit;
            busy_nx = 1'b1;
         end
         LOAD: begin
            addr_nx     = next_unit;
            busy_nx     = 1'b1;
            sel_in1_nx  = 2'b01;
            sel_in2_nx  = 2'b01;
            sel_in3_nx  = 1'b1;
            sel_in4_nx  = 2'b01;
            sel_in5_nx  = 3'b000;
            sel_temp_nx = 2'b11;
         end
         COMPUTE: begin
            addr_nx = next_unit;
            busy_nx = 1'b1;
            case (next_ustep)
               4'd0: begin sel_x1_1_nx = 2'b01; sel_x2_2_nx = 2'b01; sel_temp_nx = 2'b00; end
               4'd1: begin sel_x1_1_nx = 2'b10; sel_as_1_nx = 1'b1; sel_temp_nx = 2'b00; end
               4'd2: begin
                  // d_state accumulate: a last timestep adds the zero input instead of the future term
                  if (next_no_next) sel_in4_nx = 2'b11;
                  else              sel_in1_nx = 2'b10;
                  sel_as_2_nx = 2'b01;
                  sel_temp_nx = 2'b00;
               end
               4'd3: dstate_valid_nx = 1'b1;
               4'd4: begin sel_x1_1_nx = 2'b11; sel_x1_2_nx = 1'b1; sel_in5_nx = 3'b000; end
               4'd5: begin dgate_valid_nx = 1'b1; gate_id_nx = 2'b00; sel_in5_nx = 3'b001; end
               4'd6: begin sel_x2_2_nx = 2'b10; sel_in5_nx = 3'b010; end
               4'd7: begin dgate_valid_nx = 1'b1; gate_id_nx = 2'b01; sel_in5_nx = 3'b011; end
               4'd8: begin sel_as_2_nx = 2'b10; sel_addsub_nx = 1'b1; end
               4'd9: begin dgate_valid_nx = 1'b1; gate_id_nx = 2'b10; end
               4'd10: begin sel_x1_1_nx = 2'b01; sel_as_2_nx = 2'b11; end
               4'd11: begin dgate_valid_nx = 1'b1; gate_id_nx = 2'b11; end
               default: sel_temp_nx = 2'b10;
            endcase
         end
         DONE:    done_nx = 1'b1;
         default: done_nx = 1'b0;
      endcase
   end
endmodule

// File: tb/tb_lstm_delta_ctrl.sv
// Directed bench for lstm_delta_ctrl: a small operand-memory responder and strobe-timing model
// run inside one linear initial block; cycle 0 is the cycle in which i_start is sampled.
module tb_lstm_delta_ctrl;
   logic       clk = 1'b0;
   logic       rst, i_start, i_no_next, i_rd_valid;
   logic       o_rd_en, o_busy, o_done, o_dstate_valid, o_dgate_valid;
   logic [2:0] o_addr, o_sel_in5;
   logic [1:0] o_gate_id, o_sel_in1, o_sel_in2, o_sel_in4;
   logic       o_sel_in3, o_sel_x1_2, o_sel_as_1, o_sel_addsub;
   logic [1:0] o_sel_x1_1, o_sel_x2_2, o_sel_as_2, o_sel_temp;

   lstm_delta_ctrl dut (
      .clk(clk), .rst(rst), .i_start(i_start), .i_no_next(i_no_next), .i_rd_valid(i_rd_valid),
      .o_rd_en(o_rd_en), .o_addr(o_addr), .o_busy(o_busy), .o_done(o_done),
      .o_dstate_valid(o_dstate_valid), .o_dgate_valid(o_dgate_valid), .o_gate_id(o_gate_id),
      .o_sel_in1(o_sel_in1), .o_sel_in2(o_sel_in2), .o_sel_in4(o_sel_in4), .o_sel_in3(o_sel_in3),
      .o_sel_in5(o_sel_in5), .o_sel_x1_1(o_sel_x1_1), .o_sel_x2_2(o_sel_x2_2),
      .o_sel_as_2(o_sel_as_2), .o_sel_temp(o_sel_temp), .o_sel_x1_2(o_sel_x1_2),
      .o_sel_as_1(o_sel_as_1), .o_sel_addsub(o_sel_addsub)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc, due, rd_count, cur_unit, done_cnt, done_cyc, ds_cnt, dg_cnt;
   int strobe_err, gid_err, sel_err, addr_err;
   int base_lat, slow_unit, slow_lat;
   bit hold_valid, spam, nn;
   int rd_cyc[16];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock: sample outputs #1 after the edge, score them against the timing model, drive inputs.
   task automatic tick();
      int rel;
      @(posedge clk);
      #1;
      cyc++;
      if (o_rd_en) begin
         cur_unit = rd_count;
         if (rd_count < 16) rd_cyc[rd_count] = cyc;
         rd_count++;
         due = cyc + ((cur_unit == slow_unit) ? slow_lat : base_lat);
      end
      rel = cyc - due;
      if (o_busy && int'(o_addr) != cur_unit) addr_err++;
      if (o_dstate_valid !== (rel == 5)) strobe_err++;
      if (o_dgate_valid !== (rel == 7 || rel == 9 || rel == 11 || rel == 13)) strobe_err++;
      if (o_dstate_valid) ds_cnt++;
      if (o_dgate_valid) begin
         dg_cnt++;
         if (int'(o_gate_id) != (rel - 7) / 2) gid_err++;
      end
      if (rel == 1 && o_sel_temp !== 2'b11) sel_err++;
      if (rel == 4) begin
         if (nn && (o_sel_in4 !== 2'b11 || o_sel_in1 === 2'b10)) sel_err++;
         if (!nn && (o_sel_in1 !== 2'b10 || o_sel_in4 === 2'b11)) sel_err++;
      end
      if (o_done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      i_rd_valid = hold_valid || (cyc == due);
      i_start    = spam && o_busy;
   endtask

   task automatic start_run(input bit no_next_in);
      cyc = 0; due = -1000; rd_count = 0; cur_unit = 0; done_cnt = 0; done_cyc = -1;
      ds_cnt = 0; dg_cnt = 0; strobe_err = 0; gid_err = 0; sel_err = 0; addr_err = 0;
      for (int i = 0; i < 16; i++) rd_cyc[i] = -1;
      nn = no_next_in;
      i_no_next = no_next_in;
      i_start = 1'b1;
   endtask

   task automatic run_done(input string tag);
      int n = 0;
      while (!o_done && n < 400) begin
         tick();
         n++;
      end
      check({tag, "_done_in_bound"}, o_done, 1'b1);
   endtask

   initial begin
      rst = 1'b1; i_start = 1'b0; i_no_next = 1'b0; i_rd_valid = 1'b0;
      base_lat = 1; slow_unit = -1; slow_lat = 1; hold_valid = 1'b0; spam = 1'b0; nn = 1'b0;
      start_run(1'b0);
      i_start = 1'b0;
      repeat (3) tick();
      check("rst_busy", o_busy, 1'b0);
      check("rst_rd_en", o_rd_en, 1'b0);
      check("rst_addr", o_addr, 3'd0);
      check("rst_done", o_done, 1'b0);
      check("rst_sel_in5", o_sel_in5, 3'b111);
      check("rst_sel_temp", o_sel_temp, 2'b10);
      rst = 1'b0;
      tick();

      // Test 1: latency 1, clean run
      start_run(1'b0);
      tick();
      check("t1_c1_busy", o_busy, 1'b1);
      check("t1_c1_rd_en", o_rd_en, 1'b1);
      run_done("t1");
      check("t1_rd0", rd_cyc[0], 1);
      check("t1_rd1", rd_cyc[1], 16);
      check("t1_rd7", rd_cyc[7], 106);
      check("t1_done_cyc", done_cyc, 121);
      check("t1_done_busy", o_busy, 1'b0);
      check("t1_rd_count", rd_count, 8);
      check("t1_dstate_cnt", ds_cnt, 8);
      check("t1_dgate_cnt", dg_cnt, 32);
      check("t1_strobe_err", strobe_err, 0);
      check("t1_gate_id_err", gid_err, 0);
      check("t1_sel_err", sel_err, 0);
      check("t1_addr_err", addr_err, 0);
      tick();
      check("t1_idle_done", o_done, 1'b0);
      check("t1_idle_busy", o_busy, 1'b0);

      // Test 2: unit 2 answers 5 cycles late; restart right in the first IDLE cycle
      slow_unit = 2; slow_lat = 5;
      start_run(1'b0);
      run_done("t2");
      check("t2_period_u1", rd_cyc[2] - rd_cyc[1], 15);
      check("t2_period_u2", rd_cyc[3] - rd_cyc[2], 19);
      check("t2_done_cyc", done_cyc, 125);
      check("t2_addr_err", addr_err, 0);
      check("t2_strobe_err", strobe_err, 0);
      slow_unit = -1; slow_lat = 1;
      tick();

      // Test 3: i_start hammered while busy
      spam = 1'b1;
      start_run(1'b0);
      run_done("t3");
      spam = 1'b0;
      repeat (20) tick();
      check("t3_done_cnt", done_cnt, 1);
      check("t3_done_cyc", done_cyc, 121);
      check("t3_rd_count", rd_count, 8);
      check("t3_addr_err", addr_err, 0);

      // Test 5: last timestep, future term zeroed
      start_run(1'b1);
      run_done("t5");
      check("t5_sel_err", sel_err, 0);
      check("t5_dstate_cnt", ds_cnt, 8);
      check("t5_done_cyc", done_cyc, 121);
      tick();
      i_no_next = 1'b0;

      // Test 6: i_rd_valid stuck high
      hold_valid = 1'b1;
      start_run(1'b0);
      run_done("t6");
      check("t6_period", rd_cyc[5] - rd_cyc[4], 15);
      check("t6_done_cyc", done_cyc, 121);
      check("t6_strobe_err", strobe_err, 0);
      check("t6_dgate_cnt", dg_cnt, 32);
      hold_valid = 1'b0;
      tick();

      // Test 4: reset in COMPUTE (ustep 4) of unit 3, then restart
      start_run(1'b0);
      for (int n = 0; n < 300 && !(rd_count == 4 && cyc - due == 6); n++) tick();
      check("t4_reached_unit3", rd_count, 4);
      check("t4_pre_busy", o_busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t4_busy", o_busy, 1'b0);
      check("t4_dstate", o_dstate_valid, 1'b0);
      check("t4_dgate", o_dgate_valid, 1'b0);
      check("t4_rd_en", o_rd_en, 1'b0);
      check("t4_addr", o_addr, 3'd0);
      check("t4_sel_in5", o_sel_in5, 3'b111);
      check("t4_sel_temp", o_sel_temp, 2'b10);
      due = -1000;
      repeat (3) tick();
      check("t4_stays_idle", o_busy, 1'b0);
      start_run(1'b0);
      run_done("t4r");
      check("t4r_rd0", rd_cyc[0], 1);
      check("t4r_done_cyc", done_cyc, 121);
      check("t4r_addr_err", addr_err, 0);
      check("t4r_strobe_err", strobe_err, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
